// File: rtl/lenet_predict_mul_arb_if.sv
// lenet_predict_mul_arb_if
//   Request/response bus of the shared index multiplier.
//   Requester side (master) drives req_valid/req_a/req_b and rsp_ready;
//   the arbiter (slave) drives req_ready and rsp_valid/rsp_id/rsp_p.
//
//   Handshake rule for both directions: a transfer happens on a rising clock
//   edge where valid and ready are both high. req_ready is derived from
//   req_valid combinationally, so requesters must never derive req_valid from
//   req_ready. While rsp_valid is high and rsp_ready is low, rsp_id and rsp_p
//   stay stable.
//
//   req_a/req_b are packed: requester i lives at [i*WIDTH +: WIDTH].
interface lenet_predict_mul_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A_WIDTH  = 5,
  parameter int B_WIDTH  = 6,
  parameter int P_WIDTH  = 9
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/lenet_predict_mul_arb.sv
// lenet_predict_mul_arb
//   Round-robin arbiter feeding one shared unsigned A_WIDTH x B_WIDTH
//   multiplier through a 2-stage pipeline (operand stage, output stage).
//   Results return tagged with the requester index on a valid/ready port.
//
// Ports
//   ap_clk    : clock, rising edge
//   ap_rst_n  : asynchronous active-low reset
//   bus       : request/response bus (slave side), see the interface file
//   busy      : an operation sits in either pipeline stage
//   op_count  : completed responses, saturating at all-ones
//   cnt_clr   : synchronous clear of op_count, wins over an increment
module lenet_predict_mul_arb #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int A_WIDTH   = 5,
  parameter int B_WIDTH   = 6,
  parameter int P_WIDTH   = 9,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  lenet_predict_mul_arb_if.slave        bus,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          op_count,
  input  logic                          cnt_clr
);

  // Product is formed at least P_WIDTH wide so the low-bit slice is always legal.
  localparam int FULL_W = (A_WIDTH + B_WIDTH > P_WIDTH) ? A_WIDTH + B_WIDTH : P_WIDTH;

  logic [A_WIDTH-1:0]  a_arr [NUM_REQ];
  logic [B_WIDTH-1:0]  b_arr [NUM_REQ];

  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_id;
  logic [ID_WIDTH-1:0] scan_id;
  logic [ID_WIDTH-1:0] next_ptr;
  logic                found;
  logic                any_valid;
  logic                stall;
  logic                adv;
  logic                fire;
  logic [NUM_REQ-1:0]  req_ready_c;

  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;
  logic [FULL_W-1:0]   full_p;

  logic                rsp_valid_q;
  logic [ID_WIDTH-1:0] rsp_id_q;
  logic [P_WIDTH-1:0]  rsp_p_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*A_WIDTH +: A_WIDTH];
    assign b_arr[i] = bus.req_b[i*B_WIDTH +: B_WIDTH];
  end

  // The output stage is the only place backpressure can stop the pipe.
  assign stall     = rsp_valid_q & ~bus.rsp_ready;
  assign adv       = ~stall;
  assign any_valid = |bus.req_valid;
  assign fire      = adv & any_valid;

  // Cyclic scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    grant_id = '0;
    scan_id  = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_id = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
  end

  always_comb begin
    req_ready_c = '0;
    if (fire) req_ready_c[grant_id] = 1'b1;
  end

  assign next_ptr = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign full_p   = FULL_W'(s1_a) * FULL_W'(s1_b);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_id       <= '0;
      rr_ptr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
    end else if (adv) begin
      rsp_valid_q <= s1_valid;
      rsp_id_q    <= s1_id;
      rsp_p_q     <= full_p[P_WIDTH-1:0];
      if (fire) begin
        s1_valid <= 1'b1;
        s1_a     <= a_arr[grant_id];
        s1_b     <= b_arr[grant_id];
        s1_id    <= grant_id;
        rr_ptr   <= next_ptr;
      end else begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_count <= '0;
    end else if (cnt_clr) begin
      op_count <= '0;
    end else if (rsp_valid_q && bus.rsp_ready && (op_count != {CNT_WIDTH{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign busy          = s1_valid | rsp_valid_q;

endmodule

// File: tb/tb_lenet_predict_mul_arb.sv
// tb_lenet_predict_mul_arb
//   Directed bench for the shared multiplier arbiter. Inputs change on the
//   falling edge; outputs are sampled there too. op_count is built 4 bits
//   wide so saturation is reached in a few cycles.
module tb_lenet_predict_mul_arb;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 5;
  localparam int B_W     = 6;
  localparam int P_W     = 9;
  localparam int CNT_W   = 4;

  // ---------------- clock / reset ----------------
  logic             ap_clk   = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             cnt_clr  = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 ap_clk = ~ap_clk;

  lenet_predict_mul_arb_if #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_W), .A_WIDTH(A_W), .B_WIDTH(B_W), .P_WIDTH(P_W)
  ) bus ();

  lenet_predict_mul_arb #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_W), .A_WIDTH(A_W), .B_WIDTH(B_W),
    .P_WIDTH(P_W), .CNT_WIDTH(CNT_W)
  ) u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count),
    .cnt_clr  (cnt_clr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ID_W+P_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int p);
    exp_q.push_back({ID_W'(id), P_W'(p)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
  endtask

  // Scores a response handshake about to complete, then advances one cycle.
  task automatic tick();
    logic [ID_W+P_W-1:0] e;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(e[P_W +: ID_W]));
        chk("rsp_p", 32'(bus.rsp_p), 32'(e[P_W-1:0]));
      end
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic raw_cycle();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  // ---------------- stimulus ----------------
  int ptab [NUM_REQ];

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    chk("rst_rsp_p", 32'(bus.rsp_p), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Single op: 3*7 = 21, response visible after two edges
    set_op(0, 3, 7);
    bus.req_valid = 4'b0001;
    #1 chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    push_exp(0, 21);
    tick();
    bus.req_valid = '0;
    chk("t1_busy", 32'(busy), 1);
    chk("t1_rsp_valid_early", 32'(bus.rsp_valid), 0);
    tick();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    chk("t1_cnt_before", 32'(op_count), 0);
    tick();
    chk("t1_op_count", 32'(op_count), 1);
    chk("t1_idle", 32'(busy), 0);

    // Truncation: 31*63 = 1953 -> 1953 mod 512 = 417 (rr_ptr is 1, grant 2)
    set_op(2, 31, 63);
    bus.req_valid = 4'b0100;
    #1 chk("t2_req_ready", 32'(bus.req_ready), 32'h4);
    push_exp(2, 417);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("t2_op_count", 32'(op_count), 2);

    // Lone requester granted on consecutive cycles: 31*20 = 620 -> 108
    set_op(3, 31, 20);
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #1 chk("t3_req_ready", 32'(bus.req_ready), 32'h8);
      push_exp(3, 108);
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
    chk("t3_op_count", 32'(op_count), 4);

    // Round robin, all four valid, rr_ptr back at 0
    set_op(0, 2, 5);   ptab[0] = 10;
    set_op(1, 7, 9);   ptab[1] = 63;
    set_op(2, 17, 30); ptab[2] = 510;
    ptab[3] = 108;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t4_req_ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c >= 2) chk("t4_rsp_valid", 32'(bus.rsp_valid), 1);
      push_exp(c % 4, ptab[c % 4]);
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
    chk("t4_drained", 32'(exp_q.size()), 0);
    chk("t4_op_count", 32'(op_count), 12);

    // Backpressure: five cycles with rsp_ready low, rr_ptr at 0
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    #1 chk("t5_req_ready0", 32'(bus.req_ready), 32'h1);
    push_exp(0, 10);
    tick();
    #1 chk("t5_req_ready1", 32'(bus.req_ready), 32'h2);
    push_exp(1, 63);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_stall_ready", 32'(bus.req_ready), 0);
      chk("t5_stall_valid", 32'(bus.rsp_valid), 1);
      chk("t5_stall_id", 32'(bus.rsp_id), 0);
      chk("t5_stall_p", 32'(bus.rsp_p), 10);
      chk("t5_stall_busy", 32'(busy), 1);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1;
    tick();
    tick();
    tick();
    chk("t5_drained", 32'(exp_q.size()), 0);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t5_op_count", 32'(op_count), 14);

    // Reset with two ops in flight (rr_ptr is 2: grants 2 then 1)
    bus.req_valid = 4'b0110;
    raw_cycle();
    raw_cycle();
    bus.req_valid = '0;
    #2 ap_rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_op_count", 32'(op_count), 0);
    raw_cycle();
    ap_rst_n = 1'b1;
    // From pointer 0 the scan picks 0; a stale pointer would pick 3
    bus.req_valid = 4'b1001;
    #1 chk("t6_first_grant", 32'(bus.req_ready), 32'h1);
    push_exp(0, 10);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("t6_op_count_after", 32'(op_count), 1);

    // Saturation: 1 + 20 responses clamps at 15
    bus.req_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      push_exp(0, 10);
      tick();
    end
    bus.req_valid = '0;
    tick();
    tick();
    chk("t7_drained", 32'(exp_q.size()), 0);
    chk("t7_saturated", 32'(op_count), 15);

    // Clear coincident with a completing response
    bus.req_valid = 4'b0001;
    push_exp(0, 10);
    tick();
    bus.req_valid = '0;
    tick();
    cnt_clr = 1'b1;
    chk("t7_clr_rsp_valid", 32'(bus.rsp_valid), 1);
    tick();
    cnt_clr = 1'b0;
    chk("t7_cleared", 32'(op_count), 0);
    bus.req_valid = 4'b0001;
    push_exp(0, 10);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    chk("t7_count_resumes", 32'(op_count), 1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lenet_predict_mul_arb.md
Name: lenet_predict_mul_arb

Overview:
- Round-robin arbiter and 2-stage pipeline that shares one unsigned A_WIDTH x B_WIDTH multiplier among NUM_REQ requesters.
- Requesters are the conv/pool index-address generators in lenet_predict, e.g. row*stride and channel*size products.
- Results return on a single response port tagged with the requester ID.
- The response port uses valid/ready backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of requester tag; must equal ceil(log2(NUM_REQ)), minimum 1
A_WIDTH, 5, operand A width (unsigned)
B_WIDTH, 6, operand B width (unsigned)
P_WIDTH, 9, product width; low P_WIDTH bits of the full product
CNT_WIDTH, 16, width of the completed-operation counter

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*A_WIDTH  operand A, requester i at bits [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  operand B, packed the same way
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_WIDTH  index of the requester that issued the result
rsp_p  out  P_WIDTH  product
busy  out  1  high when any pipeline stage holds a valid op
op_count  out  CNT_WIDTH  number of completed responses, saturating
cnt_clr  in  1  synchronous clear of op_count

Behaviour:
- Reset (ap_rst_n=0, asynchronous):
  - s1_valid=0, rsp_valid=0, rr_ptr=0, op_count=0.
  - rsp_id=0, rsp_p=0, busy=0, req_ready=0.
  - In-flight operations are discarded, no response is produced, and arbitration restarts at requester 0.
- Stall condition: stall = rsp_valid & ~rsp_ready.
- Stage advance: adv = ~stall. Stage 1 moves into the output stage only when adv is high.
- Arbitration (combinational):
  - Grant g is the first i with req_valid[i]=1, searching cyclically from rr_ptr.
  - req_ready[g] = adv & (any req_valid); all other req_ready bits are 0.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept (fire = req_valid[g] & req_ready[g]) at a clock edge:
  - Stage 1 latches a=req_a[g], b=req_b[g], id=g, and sets s1_valid=1.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - If no fire occurs and adv is high, s1_valid becomes 0. rr_ptr holds.
- Stage 2 / output:
  - When adv is high: rsp_valid<=s1_valid, rsp_p<=(a*b) mod 2^P_WIDTH, rsp_id<=id.
  - The full product is A_WIDTH+B_WIDTH bits wide and is truncated. There is no saturation.
  - When stall is high, stage 1 and the output hold all their values.
- Latency:
  - A request accepted at edge k gives rsp_valid=1 after edge k+1, unless the pipeline is stalled.
  - With rsp_ready held high, throughput is 1 op/cycle.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_id and rsp_p are held stable.
- Fairness:
  - A continuously requesting requester is granted within NUM_REQ accepts.
  - If only one requester asserts req_valid, it is granted every cycle.
- busy = s1_valid | rsp_valid.
- op_count:
  - Increments on each edge where rsp_valid & rsp_ready.
  - Saturates at 2^CNT_WIDTH-1.
  - cnt_clr has priority over the increment: op_count becomes 0 even if a response completes in the same cycle.
- Simultaneous events:
  - Response handshake and new accept in the same cycle are allowed; the pipeline stays full.
  - When stalled, req_ready is all zero and no rr_ptr update occurs.

Test Plan:
- Reset with no requests -> all outputs 0. Then req_valid=0001, a0=3, b0=7 -> rsp_valid after 2 edges with rsp_id=0, rsp_p=21, op_count=1.
- Truncation: a=31, b=63 (full product 1953) -> rsp_p=417.
- All four requesters held valid with rsp_ready=1 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one response per cycle, and rsp_id sequence matches.
- Backpressure: rsp_ready=0 for 5 cycles with requests pending:
  - Pipeline fills with 2 ops, req_ready=0, and rsp_p/rsp_id stay stable.
  - On release, responses drain in order and none are lost or duplicated.
- Reset asserted mid-stream with 2 ops in flight -> rsp_valid, busy and op_count go to 0 immediately (asynchronously). After release, the first grant goes to requester 0.
- op_count preloaded near saturation via 65535 responses (or a forced small CNT_WIDTH=4: 15 responses) -> holds at max. cnt_clr pulsed coincident with a response -> 0.
